// File: rtl/seq_pattern_tx_if.sv
// Handshake/data bundle for seq_pattern_tx: request side (start/pattern/repeat_n)
// and the serial output side (PO/valid/busy/done).
interface seq_pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             PO;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_n,
    input  PO, valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_n,
    output PO, valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first, repeat_n+1 times,
// then pulses done. Define SEQ_TX_GAP_EN to insert a one-cycle gap between consecutive frames.
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int             BW      = $clog2(WIDTH);
  localparam logic [BW-1:0]  BIT_MAX = BW'(WIDTH - 1);

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state;
  // Bits still to send in the current frame after the one on PO.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] pat_lat;
  logic [BW-1:0]    bitcnt;
  logic [CNT_W-1:0] frmcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      pat_lat   <= '0;
      bitcnt    <= '0;
      frmcnt    <= '0;
      bus.PO    <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= SHIFT;
            pat_lat   <= bus.pattern;
            shreg     <= bus.pattern[WIDTH-2:0];
            frmcnt    <= bus.repeat_n;
            bitcnt    <= BIT_MAX;
            bus.PO    <= bus.pattern[WIDTH-1];
            bus.valid <= 1'b1;
            bus.busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bitcnt != '0) begin
            bitcnt <= bitcnt - BW'(1);
            shreg  <= shreg << 1;
            bus.PO <= shreg[WIDTH-2];
          end else if (frmcnt != '0) begin
`ifdef SEQ_TX_GAP_EN
            state     <= GAP;
            bus.PO    <= 1'b0;
            bus.valid <= 1'b0;
`else
            // Back-to-back frame: reload straight from the latched copy.
            frmcnt <= frmcnt - CNT_W'(1);
            bitcnt <= BIT_MAX;
            shreg  <= pat_lat[WIDTH-2:0];
            bus.PO <= pat_lat[WIDTH-1];
`endif
          end else begin
            state     <= DONE;
            bus.PO    <= 1'b0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
          end
        end
`ifdef SEQ_TX_GAP_EN
        GAP: begin
          state     <= SHIFT;
          frmcnt    <= frmcnt - CNT_W'(1);
          bitcnt    <= BIT_MAX;
          shreg     <= pat_lat[WIDTH-2:0];
          bus.PO    <= pat_lat[WIDTH-1];
          bus.valid <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bus.PO    <= 1'b0;
          bus.valid <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed, table-driven bench for seq_pattern_tx (expects SEQ_TX_GAP_EN to match the DUT build).
module tb_seq_pattern_tx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;

  seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic [3:0]       exp;   // {PO, valid, busy, done}
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got {PO,valid,busy,done}=%b, want %b", name, act, want);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.PO, bus.valid, bus.busy, bus.done};
  endfunction

  function automatic void push(input logic s, input logic [WIDTH-1:0] p,
                               input logic [CNT_W-1:0] r, input logic [3:0] e);
    vec_t v;
    v.start = s; v.pattern = p; v.repeat_n = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  // One full transmission started by a single start pulse: frames, optional gaps, DONE, IDLE.
  function automatic void push_frames(input logic [WIDTH-1:0] p, input int rep);
    for (int f = 0; f <= rep; f++) begin
      for (int b = WIDTH - 1; b >= 0; b--)
        push((f == 0 && b == WIDTH - 1), p, CNT_W'(rep), {p[b], 3'b110});
`ifdef SEQ_TX_GAP_EN
      if (f < rep) push(1'b0, p, CNT_W'(rep), 4'b0010);
`endif
    end
    push(1'b0, p, CNT_W'(rep), 4'b0001);
    push(1'b0, p, CNT_W'(rep), 4'b0000);
  endfunction

  task automatic step_and_check(input string name, input logic [3:0] want);
    @(posedge clk);
    #1;
    check(name, outs(), want);
  endtask

  initial begin
    // Single frame 1011, repeat_n=0.
    push(1'b1, 4'b1011, 4'd0, 4'b1110);
    push(1'b0, 4'b1011, 4'd0, 4'b0110);
    push(1'b0, 4'b1011, 4'd0, 4'b1110);
    push(1'b0, 4'b1011, 4'd0, 4'b1110);
    push(1'b0, 4'b1011, 4'd0, 4'b0001);
    push(1'b0, 4'b1011, 4'd0, 4'b0000);
    // Three frames of 1011.
    push_frames(4'b1011, 2);
    // Two frames, exercises the gap when enabled.
    push_frames(4'b1011, 1);
    // start/pattern churn while busy and in DONE is ignored.
    push(1'b1, 4'b1011, 4'd0, 4'b1110);
    push(1'b1, 4'b0110, 4'd3, 4'b0110);
    push(1'b1, 4'b0110, 4'd3, 4'b1110);
    push(1'b1, 4'b0110, 4'd3, 4'b1110);
    push(1'b1, 4'b0110, 4'd3, 4'b0001);
    push(1'b1, 4'b0110, 4'd3, 4'b0000);
    push(1'b0, 4'b0110, 4'd3, 4'b0000);
    // start held high: DONE, one IDLE cycle, then a new frame.
    push(1'b1, 4'b1001, 4'd0, 4'b1110);
    push(1'b1, 4'b1001, 4'd0, 4'b0110);
    push(1'b1, 4'b1001, 4'd0, 4'b0110);
    push(1'b1, 4'b1001, 4'd0, 4'b1110);
    push(1'b1, 4'b1001, 4'd0, 4'b0001);
    push(1'b1, 4'b1001, 4'd0, 4'b0000);
    push(1'b1, 4'b1001, 4'd0, 4'b1110);
    push(1'b1, 4'b1001, 4'd0, 4'b0110);
    push(1'b1, 4'b1001, 4'd0, 4'b0110);
    push(1'b1, 4'b1001, 4'd0, 4'b1110);
    push(1'b0, 4'b1001, 4'd0, 4'b0001);
    push(1'b0, 4'b1001, 4'd0, 4'b0000);
    // Maximum repeat count: 16 frames, no counter wrap.
    push_frames(4'b1100, 15);

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.pattern  = '0;
    bus.repeat_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.start    = vecs[i].start;
      bus.pattern  = vecs[i].pattern;
      bus.repeat_n = vecs[i].repeat_n;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a repeat_n=3 transmission.
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 4'b1011; bus.repeat_n = 4'd3;
    step_and_check("rst_c1", 4'b1110);
    @(negedge clk);
    bus.start = 1'b0;
    step_and_check("rst_c2", 4'b0110);
    step_and_check("rst_c3", 4'b1110);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_clear", outs(), 4'b0000);
    step_and_check("rst_held", 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) step_and_check($sformatf("rst_idle%0d", k), 4'b0000);
    // Fresh start after reset works normally.
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 4'b0110; bus.repeat_n = 4'd0;
    step_and_check("post_rst_b3", 4'b0110);
    @(negedge clk);
    bus.start = 1'b0;
    step_and_check("post_rst_b2", 4'b1110);
    step_and_check("post_rst_b1", 4'b1110);
    step_and_check("post_rst_b0", 4'b0110);
    step_and_check("post_rst_done", 4'b0001);
    step_and_check("post_rst_idle", 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
